// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch front end:
//   - fetch_state_e : FSM state encoding used by fetch_unit
//   - INSTR_BYTES   : bytes per instruction for the default 32-bit width
//   - PC_STEP       : PC increment for the default width
//   - instr_bytes() : bytes per instruction for an arbitrary width
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_DATA = 2'd2,
    S_WAIT_IDLE = 2'd3
  } fetch_state_e;

  localparam int DEFAULT_INSTR_BITWIDTH = 32;
  localparam int INSTR_BYTES            = DEFAULT_INSTR_BITWIDTH / 8;
  localparam int PC_STEP                = INSTR_BYTES;

  function automatic int instr_bytes(input int instr_bitwidth);
    return instr_bitwidth / 8;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding {pc, instruction} pairs between the ICache and decode.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   flush_i           : empty the FIFO (wins over push and pop)
//   push_i/push_data_i: write one entry
//   pop_i             : retire the head entry (only legal when non-empty)
//   head_valid_o      : FIFO non-empty
//   head_data_o       : head entry, zero when empty
//   count_o           : number of stored entries (0 .. 2^ADDR_W)
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              head_valid_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [ADDR_W:0]   count_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;

  // Storage needs no reset: entries are only visible through head_valid_o.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_valid_o = (count_q != '0);
  assign head_data_o  = head_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end sitting directly upstream of the ICache. Owns the
// PC, issues one-cycle enable/address requests, buffers returned instructions
// with their PC in fetch_fifo and hands them to decode over valid/ready.
// Redirects flush the FIFO and cause any in-flight result to be discarded.
//
// Ports:
//   clk, rst                        : clock, asynchronous active-low reset
//   ic_enable, ic_address           : request pulse and byte address to ICache
//   ic_instruction, ic_data_ready   : returned instruction and its strobe
//   ic_busy                         : ICache still working
//   redirect, redirect_pc           : flush and restart at redirect_pc
//   out_valid, out_ready            : decode handshake
//   out_instruction, out_pc         : head instruction and its PC
//
// Build option: define FETCH_STATS_EN to add saturating counters stat_fetches,
// stat_redirects and stat_discards (hierarchically readable).
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | waiting for ICache idle and a free FIFO slot
// S_REQ       | ic_enable high for this one cycle
// S_WAIT_DATA | waiting for ic_data_ready
// S_WAIT_IDLE | result taken, waiting for ic_busy to drop
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                            ADDRESS_BITWIDTH     = 32,
  parameter int                            INSTRUCTION_BITWIDTH = 32,
  parameter logic [ADDRESS_BITWIDTH-1:0]   RESET_PC             = '0,
  parameter int                            FIFO_DEPTH_BITWIDTH  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            ic_enable,
  output logic [ADDRESS_BITWIDTH-1:0]     ic_address,
  input  logic [INSTRUCTION_BITWIDTH-1:0] ic_instruction,
  input  logic                            ic_data_ready,
  input  logic                            ic_busy,
  input  logic                            redirect,
  input  logic [ADDRESS_BITWIDTH-1:0]     redirect_pc,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [INSTRUCTION_BITWIDTH-1:0] out_instruction,
  output logic [ADDRESS_BITWIDTH-1:0]     out_pc
);

  localparam int AW         = ADDRESS_BITWIDTH;
  localparam int CW         = FIFO_DEPTH_BITWIDTH + 1;
  localparam int STEP_BYTES = instr_bytes(INSTRUCTION_BITWIDTH);
  localparam logic [AW-1:0] STEP_V     = AW'(STEP_BYTES);
  localparam logic [AW-1:0] ALIGN_MASK = ~(AW'(STEP_BYTES - 1));
  localparam logic [CW-1:0] DEPTH_V    = CW'(1 << FIFO_DEPTH_BITWIDTH);

  fetch_state_e  state_q;
  logic [AW-1:0] pc_q;
  logic          discard_q;
  logic          ic_enable_q;
  logic [AW-1:0] ic_address_q;

  logic [CW-1:0] fifo_count;
  logic          fifo_valid;
  logic [AW+INSTRUCTION_BITWIDTH-1:0] fifo_head;

  logic [AW-1:0] redirect_pc_aligned;
  logic [AW-1:0] issue_pc;
  logic          in_idle, issue, data_hit, push, drop, pop;

  assign redirect_pc_aligned = redirect_pc & ALIGN_MASK;
  // A same-cycle redirect in IDLE must already steer the new request.
  assign issue_pc = redirect ? redirect_pc_aligned : pc_q;
  // WAIT_IDLE with ic_busy low behaves as IDLE so requests can go back to back.
  assign in_idle  = (state_q == S_IDLE) || (state_q == S_WAIT_IDLE && !ic_busy);
  // Only one request is ever outstanding, so count < depth guarantees a slot.
  assign issue    = in_idle && !ic_busy && (fifo_count < DEPTH_V);
  assign data_hit = (state_q == S_WAIT_DATA) && ic_data_ready;
  assign push     = data_hit && !discard_q && !redirect;
  assign drop     = data_hit && (discard_q || redirect);
  assign pop      = fifo_valid && out_ready && !redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      discard_q    <= 1'b0;
      ic_enable_q  <= 1'b0;
      ic_address_q <= '0;
    end else begin
      ic_enable_q <= 1'b0;
      case (state_q)
        S_IDLE, S_WAIT_IDLE: begin
          if (issue) begin
            state_q      <= S_REQ;
            ic_enable_q  <= 1'b1;
            ic_address_q <= issue_pc;
          end else if (in_idle) begin
            state_q <= S_IDLE;
          end
        end
        S_REQ: begin
          state_q <= S_WAIT_DATA;
          if (redirect) discard_q <= 1'b1;
        end
        S_WAIT_DATA: begin
          if (ic_data_ready) begin
            state_q   <= S_WAIT_IDLE;
            discard_q <= 1'b0;
          end else if (redirect) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (redirect)  pc_q <= redirect_pc_aligned;
      else if (push) pc_q <= pc_q + STEP_V;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetches, stat_redirects, stat_discards;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetches   <= '0;
      stat_redirects <= '0;
      stat_discards  <= '0;
    end else begin
      if (issue    && stat_fetches   != '1) stat_fetches   <= stat_fetches + 1'b1;
      if (redirect && stat_redirects != '1) stat_redirects <= stat_redirects + 1'b1;
      if (drop     && stat_discards  != '1) stat_discards  <= stat_discards + 1'b1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  fetch_fifo #(
    .DATA_W (AW + INSTRUCTION_BITWIDTH),
    .ADDR_W (FIFO_DEPTH_BITWIDTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect),
    .push_i       (push),
    .push_data_i  ({pc_q, ic_instruction}),
    .pop_i        (pop),
    .head_valid_o (fifo_valid),
    .head_data_o  (fifo_head),
    .count_o      (fifo_count)
  );

  assign ic_enable       = ic_enable_q;
  assign ic_address      = ic_address_q;
  assign out_valid       = fifo_valid;
  assign out_pc          = fifo_head[AW+INSTRUCTION_BITWIDTH-1:INSTRUCTION_BITWIDTH];
  assign out_instruction = fifo_head[INSTRUCTION_BITWIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_enable;
  logic [31:0] ic_address;
  logic [31:0] ic_instruction;
  logic        ic_data_ready;
  logic        ic_busy;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .ic_enable       (ic_enable),
    .ic_address      (ic_address),
    .ic_instruction  (ic_instruction),
    .ic_data_ready   (ic_data_ready),
    .ic_busy         (ic_busy),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 1;
  int tail     = 1;
  int pulse_cnt = 0;

  logic [31:0] exp_addr_q [$];
  logic [63:0] exp_out_q  [$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // ICache contents, hand-assigned.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hB7C6_A980;
      32'h0000_0004: return 32'h3F5A_2E14;
      32'h0000_0008: return 32'hAB4C_3E6F;
      32'h0000_000C: return 32'h5E6F_7081;
      32'h0000_0010: return 32'hD5B8_A9C4;
      32'h0000_0044: return 32'h0A1B_2C3D;
      default:       return ~a;
    endcase
  endfunction

  // ICache stub: busy from the request until data_ready plus 'tail' cycles.
  int          m_state = 0;
  int          m_cnt   = 0;
  logic [31:0] m_addr;
  initial begin
    ic_busy = 1'b0; ic_data_ready = 1'b0; ic_instruction = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ic_busy = 1'b0; ic_data_ready = 1'b0; ic_instruction = '0; m_state = 0;
      end else begin
        case (m_state)
          0: if (ic_enable) begin
               chk("issue_while_busy", {63'd0, ic_busy}, 64'd0);
               m_addr = ic_address; m_cnt = lat; ic_busy = 1'b1; m_state = 1;
             end
          1: if (m_cnt > 1) m_cnt--;
             else begin
               ic_data_ready = 1'b1; ic_instruction = instr_at(m_addr); m_state = 2;
             end
          2: begin
               ic_data_ready = 1'b0;
               if (tail == 0) begin ic_busy = 1'b0; m_state = 0; end
               else begin m_cnt = tail; m_state = 3; end
             end
          default: if (m_cnt > 1) m_cnt--;
                   else begin ic_busy = 1'b0; m_state = 0; end
        endcase
      end
    end
  end

  // Monitor: request pulses and the decode stream against the scoreboard.
  logic prev_en = 1'b0;
  initial begin
    logic [31:0] ea;
    logic [63:0] eo;
    forever begin
      @(negedge clk);
      if (!rst) prev_en = 1'b0;
      else begin
        if (ic_enable) begin
          pulse_cnt++;
          chk("enable_single_cycle", {63'd0, prev_en}, 64'd0);
          if (exp_addr_q.size() > 0) begin
            ea = exp_addr_q.pop_front();
            chk("ic_address", {32'd0, ic_address}, {32'd0, ea});
          end
        end
        prev_en = ic_enable;
        if (out_valid && out_ready && !redirect && exp_out_q.size() > 0) begin
          eo = exp_out_q.pop_front();
          chk("out_pc_instr", {out_pc, out_instruction}, eo);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_out(input logic [31:0] pc, input logic [31:0] ins);
    exp_out_q.push_back({pc, ins});
  endtask

  task automatic wait_drain(input int bound);
    int i = 0;
    while ((exp_addr_q.size() + exp_out_q.size()) != 0 && i < bound) begin
      step(); i++;
    end
    chk("drain", 64'(exp_addr_q.size() + exp_out_q.size()), 64'd0);
    exp_addr_q.delete(); exp_out_q.delete();
  endtask

  task automatic wait_enable(input int bound);
    int i = 0;
    while (!ic_enable && i < bound) begin step(); i++; end
    chk("enable_seen", {63'd0, ic_enable}, 64'd1);
  endtask

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    repeat (2) step();
    chk("rst_ic_enable", {63'd0, ic_enable}, 64'd0);
    chk("rst_ic_address", {32'd0, ic_address}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_instr", {32'd0, out_instruction}, 64'd0);
    chk("rst_out_pc", {32'd0, out_pc}, 64'd0);

    // Sequential fetch from RESET_PC.
    exp_addr_q = '{32'h0, 32'h4, 32'h8};
    push_out(32'h0, 32'hB7C6_A980);
    push_out(32'h4, 32'h3F5A_2E14);
    push_out(32'h8, 32'hAB4C_3E6F);
    rst = 1'b1;
    wait_drain(200);

    // Decode stalled: exactly four requests fill the FIFO, then drain.
    rst = 1'b0; out_ready = 1'b0; step();
    pulse_cnt = 0;
    exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    step(); rst = 1'b1;
    repeat (60) step();
    chk("full_pulse_count", 64'(pulse_cnt), 64'd4);
    chk("full_out_valid", {63'd0, out_valid}, 64'd1);
    chk("full_out_pc", {32'd0, out_pc}, 64'd0);
    chk("full_out_instr", {32'd0, out_instruction}, {32'd0, 32'hB7C6_A980});
    push_out(32'h0, 32'hB7C6_A980);
    push_out(32'h4, 32'h3F5A_2E14);
    push_out(32'h8, 32'hAB4C_3E6F);
    push_out(32'hC, 32'h5E6F_7081);
    push_out(32'h10, 32'hD5B8_A9C4);
    out_ready = 1'b1;
    wait_drain(200);

    // Redirect during WAIT_DATA on a slow miss: in-flight result dropped.
    lat = 6; tail = 0;
    rst = 1'b0; step(); step();
    exp_addr_q = '{32'h0, 32'h44};
    push_out(32'h44, 32'h0A1B_2C3D);
    rst = 1'b1;
    wait_enable(50);
    step();
    redirect = 1'b1; redirect_pc = 32'h47;
    step();
    redirect = 1'b0;
    wait_drain(200);
`ifdef FETCH_STATS_EN
    chk("stat_discards", {32'd0, dut.stat_discards}, 64'd1);
`endif
    lat = 1; tail = 1;

    // Redirect coinciding with a pop: pop ignored, FIFO empty next cycle.
    rst = 1'b0; out_ready = 1'b0; step(); step();
    rst = 1'b1;
    repeat (40) step();
    chk("pre_redirect_valid", {63'd0, out_valid}, 64'd1);
    exp_addr_q = '{32'h100};
    push_out(32'h100, 32'hFFFF_FEFF);
    redirect = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1;
    step();
    redirect = 1'b0; out_ready = 1'b0;
    chk("post_redirect_valid", {63'd0, out_valid}, 64'd0);
    step();
    out_ready = 1'b1;
    wait_drain(200);

    // PC wrap: unaligned redirect to the top of the address space.
    rst = 1'b0; out_ready = 1'b0; step(); step();
    rst = 1'b1;
    repeat (40) step();
    exp_addr_q = '{32'hFFFF_FFFC, 32'h0};
    push_out(32'hFFFF_FFFC, 32'h0000_0003);
    push_out(32'h0, 32'hB7C6_A980);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0; out_ready = 1'b1;
    wait_drain(200);

    // Asynchronous reset in the middle of WAIT_DATA.
    out_ready = 1'b0; lat = 6;
    wait_enable(50);
    step();
    #2 rst = 1'b0;
    #1;
    chk("async_ic_enable", {63'd0, ic_enable}, 64'd0);
    chk("async_ic_address", {32'd0, ic_address}, 64'd0);
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_out_instr", {32'd0, out_instruction}, 64'd0);
    chk("async_out_pc", {32'd0, out_pc}, 64'd0);
    lat = 1;
    exp_addr_q = '{32'h0};
    step();
    rst = 1'b1;
    wait_drain(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
